jtag_uart_bridge: RTL and testbench

//  Parametrised successor to the fixed JTAG UART stream adapter. It is an Avalon-MM master

---
 rtl/jtag_uart_bridge_pkg.sv | 36 +++
 rtl/byte_fifo.sv | 58 +++++
 rtl/jtag_uart_bridge.sv | 190 +++++++++++++++++++
 tb/tb_jtag_uart_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_bridge_pkg.sv
// Shared types and constants for the JTAG UART bridge.
// Build option: JTAG_UART_BRIDGE_STATS_EN adds transfer/poll statistics ports.
package jtag_uart_bridge_pkg;

  localparam int BYTE_W = 8;

  // Avalon byte addresses of the JTAG UART slave registers
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_CTRL = 3'd4;

  // DATA register: RVALID flag; CONTROL register: write-space field
  localparam int RVALID_BIT = 15;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_RD_CTRL = 2'd3
  } state_t;

  // Observation bundle so checkers can see the controller without probing internals
  typedef struct packed {
    state_t      state;
    logic [15:0] wspace;
    logic        last_was_read;
    logic        expired;
  } dbg_t;

  // Extract the write-space credit from a CONTROL register read
  function automatic logic [15:0] wspace_field(input logic [31:0] ctrl);
    return ctrl[WSPACE_MSB:WSPACE_LSB];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with count-based full/empty.
// Push while full and pop while empty are ignored; full/empty are judged on the
// count before this cycle's pop, so a push into a full FIFO is blocked even if
// the same cycle pops.
module byte_fifo
  import jtag_uart_bridge_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, needs no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_uart_bridge.sv
// Avalon-MM master that polls a JTAG UART slave on behalf of a pair of byte
// streams. Buffers TX and RX bytes, caches the slave's write-space credit,
// throttles unproductive polls and alternates TX writes with RX data reads.
// Build option: JTAG_UART_BRIDGE_STATS_EN adds tx_count/rx_count/poll_count.
//
// Handshakes: an Avalon request (read or write) is presented with address and
// writedata held stable and completes in the first cycle where waitrequest=0;
// readdata is sampled in that same cycle. The stream side is valid/ready style:
// in_get is asserted (and the byte taken) when in_canGet=1 and TX has room;
// out_get pops the RX head when out_canGet=1 and is ignored otherwise.
module jtag_uart_bridge
  import jtag_uart_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int POLL_GAP = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [2:0]  address,
  output logic [31:0] writedata,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        in_canGet,
  input  logic [7:0]  in_getData,
  output logic        in_get,
  output logic        out_canGet,
  output logic [7:0]  out_getData,
  input  logic        out_get,
  output dbg_t        dbg
`ifdef JTAG_UART_BRIDGE_STATS_EN
  ,
  output logic [31:0] tx_count,
  output logic [31:0] rx_count,
  output logic [31:0] poll_count
`endif
);

  localparam int TW = $clog2(POLL_GAP + 2);
  localparam logic [TW-1:0] GAP_LOAD = TW'(POLL_GAP);

  state_t        state;
  state_t        state_next;
  logic [15:0]   wspace;
  logic [TW-1:0] timer;
  logic          last_was_read;
  logic          expired;

  logic          tx_full;
  logic          tx_empty;
  logic [7:0]    tx_head;
  logic          tx_pop;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;

  logic          rd_ok;
  logic          tx_accept;
  logic          data_accept;
  logic          ctrl_accept;
  logic          unproductive;
  logic [15:0]   new_wspace;
  logic          unused_readdata_bits;

  // Only the RVALID flag, the data byte and the write-space field are meaningful
  assign unused_readdata_bits = ^{readdata[14:8]};

  assign in_get     = in_canGet & ~tx_full;
  assign out_canGet = ~rx_empty;

  assign expired     = (timer == '0);
  assign rd_ok       = ~rx_full & expired;
  assign tx_accept   = (state == ST_WRITE)   & ~waitrequest;
  assign data_accept = (state == ST_RD_DATA) & ~waitrequest;
  assign ctrl_accept = (state == ST_RD_CTRL) & ~waitrequest;
  assign tx_pop      = tx_accept;
  assign rx_push     = data_accept & readdata[RVALID_BIT];
  assign new_wspace  = wspace_field(readdata);

  // A poll is unproductive when it brings no byte or no write credit
  assign unproductive = (data_accept & ~readdata[RVALID_BIT]) |
                        (ctrl_accept & (new_wspace == 16'd0));

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_get),
    .push_data (in_getData),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (readdata[7:0]),
    .pop       (out_get),
    .head      (out_getData),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state selection and Avalon request decode
  always_comb begin
    state_next = state;
    write      = 1'b0;
    read       = 1'b0;
    address    = ADDR_DATA;
    writedata  = '0;
    case (state)
      ST_IDLE: begin
        // A pending TX byte with credit wins unless the previous access was a
        // write and a data read is also due, which gives strict alternation.
        if (!tx_empty && (wspace != 16'd0) && (last_was_read || !rd_ok))
          state_next = ST_WRITE;
        else if (rd_ok)
          state_next = ST_RD_DATA;
        else if (!tx_empty && (wspace == 16'd0) && expired)
          state_next = ST_RD_CTRL;
      end
      ST_WRITE: begin
        write     = 1'b1;
        writedata = {24'b0, tx_head};
        if (!waitrequest) state_next = ST_IDLE;
      end
      ST_RD_DATA: begin
        read = 1'b1;
        if (!waitrequest) state_next = ST_IDLE;
      end
      ST_RD_CTRL: begin
        read    = 1'b1;
        address = ADDR_CTRL;
        if (!waitrequest) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write-space credit and last-access fairness flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wspace        <= 16'd0;
      last_was_read <= 1'b0;
    end else begin
      if (tx_accept) begin
        if (wspace != 16'd0) wspace <= wspace - 16'd1;
        last_was_read <= 1'b0;
      end
      if (data_accept) last_was_read <= 1'b1;
      if (ctrl_accept) wspace <= new_wspace;
    end
  end

  // Poll throttle: reload after an unproductive poll, count down and hold at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             timer <= '0;
    else if (unproductive) timer <= GAP_LOAD;
    else if (!expired)     timer <= timer - 1'b1;
  end

  assign dbg = '{state: state, wspace: wspace, last_was_read: last_was_read,
                 expired: expired};

`ifdef JTAG_UART_BRIDGE_STATS_EN
  // Free-running statistics, wrapping modulo 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_count   <= '0;
      rx_count   <= '0;
      poll_count <= '0;
    end else begin
      if (tx_accept)                  tx_count   <= tx_count + 32'd1;
      if (rx_push)                    rx_count   <= rx_count + 32'd1;
      if (data_accept || ctrl_accept) poll_count <= poll_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Directed bench for jtag_uart_bridge: the bench plays the Avalon slave and the
// stream endpoints, with hand-derived expected values and an RX byte queue.
module tb_jtag_uart_bridge;
  import jtag_uart_bridge_pkg::*;

  localparam int G   = 8;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        in_canGet;
  logic [7:0]  in_getData;
  logic        in_get;
  logic        out_canGet;
  logic [7:0]  out_getData;
  logic        out_get;
  dbg_t        dbg;
`ifdef JTAG_UART_BRIDGE_STATS_EN
  logic [31:0] tx_count;
  logic [31:0] rx_count;
  logic [31:0] poll_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  jtag_uart_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .POLL_GAP(G)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .writedata   (writedata),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .in_canGet   (in_canGet),
    .in_getData  (in_getData),
    .in_get      (in_get),
    .out_canGet  (out_canGet),
    .out_getData (out_getData),
    .out_get     (out_get),
    .dbg         (dbg)
`ifdef JTAG_UART_BRIDGE_STATS_EN
    ,
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .poll_count  (poll_count)
`endif
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Slave driver: wait for a request, check it, stall it, then accept it.
  // Called and returns at a negedge.
  task automatic serve(input string tag, input logic is_wr, input logic [2:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits,
                       output int gap);
    int n;
    logic [2:0]  a0;
    logic [31:0] d0;
    n = 0;
    while (!(read || write) && n < 200) begin
      @(negedge clock);
      n++;
    end
    gap = n;
    check({tag, "_req"}, 32'(read || write), 32'd1);
    check({tag, "_write"}, 32'(write), 32'(is_wr));
    check({tag, "_read"}, 32'(read), 32'(!is_wr));
    check({tag, "_addr"}, 32'(address), 32'(addr));
    check({tag, "_wdata"}, writedata, is_wr ? wd : 32'd0);
    a0 = address;
    d0 = writedata;
    readdata = rd;
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      check({tag, "_hold_req"}, 32'(is_wr ? write : read), 32'd1);
      check({tag, "_hold_addr"}, 32'(address), 32'(a0));
      check({tag, "_hold_data"}, writedata, d0);
    end
    waitrequest = 1'b0;
    @(negedge clock);
    waitrequest = 1'b1;
    readdata    = '0;
    if (!is_wr && addr == ADDR_DATA && rd[RVALID_BIT]) exp_q.push_back(rd[7:0]);
  endtask

  // TX source driver: offer one byte for one cycle
  task automatic push_tx(input logic [7:0] b, input logic exp_taken);
    in_canGet  = 1'b1;
    in_getData = b;
    #1;
    check("in_get", 32'(in_get), 32'(exp_taken));
    @(negedge clock);
    in_canGet = 1'b0;
  endtask

  // RX sink driver: pop the head and compare with the scoreboard
  task automatic pop_rx();
    logic [7:0] e;
    #1;
    check("rx_can_get", 32'(out_canGet), 32'd1);
    if (exp_q.size() == 0) begin
      check("rx_q_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rx_head", 32'(out_getData), 32'(e));
    end
    out_get = 1'b1;
    @(negedge clock);
    out_get = 1'b0;
  endtask

  initial begin
    int gap;
    int n_rd;
    int n;
    logic [7:0] b;
    reset       = 1'b1;
    waitrequest = 1'b1;
    readdata    = '0;
    in_canGet   = 1'b0;
    in_getData  = '0;
    out_get     = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_in_get", 32'(in_get), 32'd0);
    check("rst_out_can", 32'(out_canGet), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("rst_wspace", 32'(dbg.wspace), 32'd0);
    reset = 1'b0;

    // DATA read with RVALID delivers a byte; an empty read throttles polling
    serve("rd55", 1'b0, ADDR_DATA, 32'd0, 32'h0002_8055, 2, gap);
    check("rx_valid", 32'(out_canGet), 32'd1);
    check("rx_byte", 32'(out_getData), 32'h55);
    serve("rd_none", 1'b0, ADDR_DATA, 32'd0, 32'h0000_0000, 0, gap);
    check("rx_still_one", 32'(out_getData), 32'h55);
    serve("rd61", 1'b0, ADDR_DATA, 32'd0, 32'h0000_8061, 0, gap);
    check("data_gap", 32'(gap >= G + 1 && gap <= G + 2), 32'd1);

    // Fill RX: polling stops while full, resumes after one pop
    serve("rd62", 1'b0, ADDR_DATA, 32'd0, 32'h0000_8062, 0, gap);
    serve("rd63", 1'b0, ADDR_DATA, 32'd0, 32'h0000_8063, 0, gap);
    n_rd = 0;
    repeat (20) begin
      @(negedge clock);
      if (read || write) n_rd++;
    end
    check("full_no_poll", 32'(n_rd), 32'd0);
    pop_rx();
    check("head_after_pop", 32'(out_getData), 32'h61);
    serve("rd64", 1'b0, ADDR_DATA, 32'd0, 32'h0000_8064, 0, gap);

    // No credit: CONTROL returns zero, is re-polled after the gap, then one write
    push_tx(8'h33, 1'b1);
    serve("ctrl0", 1'b0, ADDR_CTRL, 32'd0, 32'h0000_0000, 1, gap);
    serve("ctrl1", 1'b0, ADDR_CTRL, 32'd0, 32'h0001_0000, 0, gap);
    check("ctrl_gap", 32'(gap >= G + 1 && gap <= G + 2), 32'd1);
    serve("wr33", 1'b1, ADDR_DATA, 32'h0000_0033, 32'd0, 0, gap);
    check("wspace_zero", 32'(dbg.wspace), 32'd0);

    // Credit of 64, write held by waitrequest for 3 cycles
    push_tx(8'h41, 1'b1);
    serve("ctrl40", 1'b0, ADDR_CTRL, 32'd0, 32'h0040_0000, 0, gap);
    serve("wr41", 1'b1, ADDR_DATA, 32'h0000_0041, 32'd0, 3, gap);
    check("wspace_63", 32'(dbg.wspace), 32'd63);

    // Drain RX, fill TX (fifth byte refused), then TX/RX alternate
    repeat (4) pop_rx();
    #1;
    check("rx_drained", 32'(out_canGet), 32'd0);
    @(negedge clock);
    for (int i = 0; i < TXD; i++) push_tx(8'hA0 + 8'(i), 1'b1);
    push_tx(8'hA4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b = 8'hB0 + 8'(i);
      serve("alt_rd", 1'b0, ADDR_DATA, 32'd0, {16'h0000, 8'h80, b}, 0, gap);
      serve("alt_wr", 1'b1, ADDR_DATA, {24'd0, 8'hA0 + 8'(i)}, 32'd0, 0, gap);
    end
    check("wspace_59", 32'(dbg.wspace), 32'd59);
    check("rx_head_b0", 32'(out_getData), 32'hB0);
`ifdef JTAG_UART_BRIDGE_STATS_EN
    check("tx_count", tx_count, 32'd6);
    check("rx_count", rx_count, 32'd9);
    check("poll_count", poll_count, 32'd13);
`endif

    // Reset in the middle of a stalled write
    push_tx(8'hC0, 1'b1);
    n = 0;
    while (!write && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("mid_wr_seen", 32'(write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_write", 32'(write), 32'd0);
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_addr", 32'(address), 32'd0);
    check("mid_rst_wdata", writedata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_out_can", 32'(out_canGet), 32'd0);
    check("post_rst_wspace", 32'(dbg.wspace), 32'd0);
`ifdef JTAG_UART_BRIDGE_STATS_EN
    check("post_rst_tx_count", tx_count, 32'd0);
    check("post_rst_poll_count", poll_count, 32'd0);
`endif
    exp_q.delete();
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
